// File: rtl/reg_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bldc_reg_pkg
// Shared definitions for the register access arbiter and the register module:
//   - arbiter FSM state encodings (ARB_IDLE / ARB_ISSUE / ARB_RDATA)
//   - owner codes identifying which requester holds the current access
//   - register index constants shared with Register_Module_1
//   - ageWidth(): width of the tuner aging counter (minimum 4 bits)
// No ports (package).
// ---------------------------------------------------------------------------
package bldc_reg_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RDATA = 2'd2
  } arb_state_e;

  localparam logic OWNER_H = 1'b0;
  localparam logic OWNER_T = 1'b1;

  localparam logic [7:0] REG_IDX_40 = 8'h40;
  localparam logic [7:0] REG_IDX_41 = 8'h41;
  localparam logic [7:0] REG_IDX_42 = 8'h42;
  localparam logic [7:0] REG_IDX_43 = 8'h43;
  localparam logic [7:0] REG_IDX_44 = 8'h44;
  localparam logic [7:0] REG_IDX_48 = 8'h48;

  // The age counter must be able to hold the limit itself, and is never
  // narrower than 4 bits so small limits keep the same register layout.
  function automatic int unsigned ageWidth(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter_if
// Bundles the host (H) and tuner (T) request/response handshakes together with
// the register-module access port.
//   h_req/h_we/h_addr/h_wdata     host request (level, held until h_gnt)
//   h_gnt/h_rvalid/h_rdata        host grant pulse, read-valid pulse, read data
//   t_*                           same set for the tuner
//   reg_write/reg_read            strobes to the register module
//   reg_index/reg_wdata           index and write data to the register module
//   reg_rdata                     read data from the register module
//   busy                          arbiter not idle
// Modports: slave = arbiter side, master = requesters/register-module side.
// ---------------------------------------------------------------------------
interface reg_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic              t_req;
  logic              t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_gnt;
  logic              t_rvalid;
  logic [DATA_W-1:0] t_rdata;

  logic              reg_write;
  logic              reg_read;
  logic [ADDR_W-1:0] reg_index;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  logic              busy;

  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    input  t_req, t_we, t_addr, t_wdata,
    output t_gnt, t_rvalid, t_rdata,
    output reg_write, reg_read, reg_index, reg_wdata,
    input  reg_rdata,
    output busy
  );

  modport master (
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    output t_req, t_we, t_addr, t_wdata,
    input  t_gnt, t_rvalid, t_rdata,
    input  reg_write, reg_read, reg_index, reg_wdata,
    output reg_rdata,
    input  busy
  );

endinterface

// File: rtl/reg_access_arbiter_age_ctr.sv
// ---------------------------------------------------------------------------
// reg_arb_age_ctr
// Saturating wait-age counter for the tuner port. Counts cycles in which the
// tuner is requesting but not granted, clears when the tuner is granted, and
// stops at LIMIT. Used only when ARB_AGING_EN is defined.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset (counter -> 0)
//   inc_i      tuner requesting and not granted this cycle
//   clr_i      tuner granted this cycle (has priority over inc_i)
//   atLimit_o  counter has reached LIMIT
// ---------------------------------------------------------------------------
module reg_arb_age_ctr
  import bldc_reg_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic atLimit_o
);

  localparam int unsigned W = ageWidth(LIMIT);

  logic [W-1:0] age_q;
  logic [W-1:0] age_d;

  // Next age: a grant always wins over an increment so the count restarts
  // from zero on the cycle after the tuner is served.
  always_comb begin
    age_d = age_q;
    if (clr_i) begin
      age_d = '0;
    end else if (inc_i && (age_q != W'(LIMIT))) begin
      age_d = age_q + 1'b1;
    end
  end

  // Age register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign atLimit_o = (age_q == W'(LIMIT));

endmodule

// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
// Shares the register module's single access port between the I2C slave
// (host, H) and the autotuner/telemetry writer (tuner, T). One access at a
// time: IDLE (grant + latch) -> ISSUE (one strobe) -> RDATA (reads only) ->
// IDLE. Read data is returned to whichever requester issued the read.
// Host has priority on a tie. Optional build macro ARB_AGING_EN adds an age
// counter that lets a tuner waiting AGE_LIMIT cycles win over the host.
// Ports:
//   clk   clock (slow_clk1)
//   rst   synchronous active-low reset
//   bus   reg_access_arbiter_if.slave (host, tuner and register-module signals)
// Parameters: ADDR_W, DATA_W, AGE_LIMIT (only meaningful with ARB_AGING_EN).
// ---------------------------------------------------------------------------
module reg_access_arbiter
  import bldc_reg_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int AGE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_access_arbiter_if.slave   bus
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] wdata_q;
  logic              regWrite_q;
  logic              regRead_q;
  logic              hRvalid_q;
  logic              tRvalid_q;
  logic [DATA_W-1:0] hRdata_q;
  logic [DATA_W-1:0] tRdata_q;

  logic              owner_d;
  logic              we_d;
  logic [ADDR_W-1:0] index_d;
  logic [DATA_W-1:0] wdata_d;

  logic              hGnt;
  logic              tGnt;
  logic              tAged;

  if (AGE_LIMIT < 1) begin : g_bad_age_limit
    $error("reg_access_arbiter: AGE_LIMIT must be at least 1");
  end

`ifdef ARB_AGING_EN
  reg_arb_age_ctr #(
    .LIMIT (AGE_LIMIT)
  ) u_ageCtr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (bus.t_req & ~tGnt),
    .clr_i     (tGnt),
    .atLimit_o (tAged)
  );
`else
  assign tAged = 1'b0;
`endif

  // Grant decision. Grants are only given in IDLE and are combinational so
  // the winner sees its grant in the same cycle it is accepted and can drop
  // its request on the next one. No grant while reset is asserted, because
  // the latched command would be discarded at the edge anyway.
  always_comb begin
    hGnt = 1'b0;
    tGnt = 1'b0;
    if (rst && (state_q == ARB_IDLE)) begin
      if (bus.t_req && (tAged || !bus.h_req)) begin
        tGnt = 1'b1;
      end else if (bus.h_req) begin
        hGnt = 1'b1;
      end
    end
  end

  // Command of the winning requester, latched on the grant edge.
  always_comb begin
    owner_d = tGnt ? OWNER_T     : OWNER_H;
    we_d    = tGnt ? bus.t_we    : bus.h_we;
    index_d = tGnt ? bus.t_addr  : bus.h_addr;
    wdata_d = tGnt ? bus.t_wdata : bus.h_wdata;
  end

  // Access sequencer. Strobes and read-valid pulses are registered and
  // default low each cycle so they last exactly one cycle. The index and
  // write data keep their last latched value between accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_H;
      we_q       <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      regWrite_q <= 1'b0;
      regRead_q  <= 1'b0;
      hRvalid_q  <= 1'b0;
      tRvalid_q  <= 1'b0;
      hRdata_q   <= '0;
      tRdata_q   <= '0;
    end else begin
      regWrite_q <= 1'b0;
      regRead_q  <= 1'b0;
      hRvalid_q  <= 1'b0;
      tRvalid_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (hGnt || tGnt) begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
            regWrite_q <= we_d;
            regRead_q  <= ~we_d;
            state_q    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (we_q) begin
            state_q <= ARB_IDLE;
          end else begin
            hRvalid_q <= (owner_q == OWNER_H);
            tRvalid_q <= (owner_q == OWNER_T);
            state_q   <= ARB_RDATA;
          end
        end
        ARB_RDATA: begin
          if (owner_q == OWNER_T) begin
            tRdata_q <= bus.reg_rdata;
          end else begin
            hRdata_q <= bus.reg_rdata;
          end
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // The register module presents read data in the RDATA cycle, so the owner
  // sees it directly alongside its rvalid pulse; the captured copy is held
  // from then on until that requester's next read.
  assign bus.h_rdata   = hRvalid_q ? bus.reg_rdata : hRdata_q;
  assign bus.t_rdata   = tRvalid_q ? bus.reg_rdata : tRdata_q;
  assign bus.h_gnt     = hGnt;
  assign bus.t_gnt     = tGnt;
  assign bus.h_rvalid  = hRvalid_q;
  assign bus.t_rvalid  = tRvalid_q;
  assign bus.reg_write = regWrite_q;
  assign bus.reg_read  = regRead_q;
  assign bus.reg_index = index_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_access_arbiter
// Directed bench for reg_access_arbiter plus a short mixed-traffic section.
// A small behavioural register module (memory, read data one cycle after the
// read strobe) answers the arbiter's access port. Expectations follow the
// ARB_AGING_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_reg_access_arbiter;
  import bldc_reg_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;

  reg_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  reg_access_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .AGE_LIMIT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Behavioural register module: writes land on the strobe edge, read data
  // appears the cycle after the read strobe.
  logic [7:0] tbMem [256];
  always @(posedge clk) begin
    if (ifc.reg_write) tbMem[ifc.reg_index] <= ifc.reg_wdata;
    if (ifc.reg_read)  ifc.reg_rdata <= tbMem[ifc.reg_index];
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic hReq, input logic hWe,
                               input logic [7:0] hAddr, input logic [7:0] hWdata,
                               input logic tReq, input logic tWe,
                               input logic [7:0] tAddr, input logic [7:0] tWdata);
    ifc.h_req   = hReq;
    ifc.h_we    = hWe;
    ifc.h_addr  = hAddr;
    ifc.h_wdata = hWdata;
    ifc.t_req   = tReq;
    ifc.t_we    = tWe;
    ifc.t_addr  = tAddr;
    ifc.t_wdata = tWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // {h_gnt,h_rvalid,t_gnt,t_rvalid,reg_write,reg_read,busy}
  function automatic logic [31:0] outFlags();
    return 32'({ifc.h_gnt, ifc.h_rvalid, ifc.t_gnt, ifc.t_rvalid,
                ifc.reg_write, ifc.reg_read, ifc.busy});
  endfunction

  // {reg_write, reg_read, reg_index, reg_wdata}
  function automatic logic [31:0] strobeBus();
    return 32'({ifc.reg_write, ifc.reg_read, ifc.reg_index, ifc.reg_wdata});
  endfunction

  // Mixed-traffic requester state.
  logic [7:0] addrList [6];
  logic       hPend, hWaitRd, tPend, tWaitRd, gntPrev, prevWe, allowNew;
  logic       hWe, tWe;
  logic [7:0] hAddr, hWdata, tAddr, tWdata, hExp, tExp, prevAddr, prevWdata;
  int         numGnt, numStrobe, numRd, hWaitCnt, tWaitCnt;
  int         firstTGnt, hGntBefore;

  initial begin
    addrList[0] = REG_IDX_40; addrList[1] = REG_IDX_41; addrList[2] = REG_IDX_42;
    addrList[3] = REG_IDX_43; addrList[4] = REG_IDX_44; addrList[5] = REG_IDX_48;

    // ---------------- Reset state ----------------
    rst = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    nextCycle(); nextCycle(); nextCycle();
    @(negedge clk);
    checkOutput("reset_flags", outFlags(), 32'h0);
    checkOutput("reset_h_rdata", 32'(ifc.h_rdata), 32'h0);
    checkOutput("reset_t_rdata", 32'(ifc.t_rdata), 32'h0);
    checkOutput("reset_strobe_bus", strobeBus(), 32'h0);
    nextCycle();
    rst = 1'b1;
    nextCycle();

    // ---------------- T2: host write 0x41 <= 0x5A ----------------
    applyStimulus(1, 1, 8'h41, 8'h5A, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t2_gnt_N", outFlags(), 32'b1000000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t2_strobe_N1", strobeBus(), 32'h2_41_5A);
    checkOutput("t2_flags_N1", outFlags(), 32'b0000101);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_flags_N2", outFlags(), 32'b0000000);
    checkOutput("t2_index_held", 32'(ifc.reg_index), 32'h41);

    // ---------------- Tuner write 0x48 <= 0x03 ----------------
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h48, 8'h03);
    @(negedge clk);
    checkOutput("tw_gnt_N", outFlags(), 32'b0010000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("tw_strobe_N1", strobeBus(), 32'h2_48_03);
    nextCycle();

    // ---------------- T3: tuner read 0x48 ----------------
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h48, 8'h00);
    @(negedge clk);
    checkOutput("t3_gnt_N", outFlags(), 32'b0010000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t3_flags_N1", outFlags(), 32'b0000011);
    checkOutput("t3_index_N1", 32'(ifc.reg_index), 32'h48);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_flags_N2", outFlags(), 32'b0001001);
    checkOutput("t3_rdata_N2", 32'(ifc.t_rdata), 32'h03);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_flags_N3", outFlags(), 32'b0000000);
    checkOutput("t3_rdata_held", 32'(ifc.t_rdata), 32'h03);
    checkOutput("t3_h_rdata_untouched", 32'(ifc.h_rdata), 32'h00);
    nextCycle();

    // ---------------- T4: simultaneous host and tuner writes ----------------
    applyStimulus(1, 1, 8'h42, 8'h11, 1, 1, 8'h43, 8'h22);
    @(negedge clk);
    checkOutput("t4_host_first", outFlags(), 32'b1000000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h43, 8'h22);
    @(negedge clk);
    checkOutput("t4_host_strobe", strobeBus(), 32'h2_42_11);
    checkOutput("t4_no_tgnt_busy", 32'(ifc.t_gnt), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_tgnt_2_later", outFlags(), 32'b0010000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t4_tuner_strobe", strobeBus(), 32'h2_43_22);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_idle", outFlags(), 32'b0000000);
    nextCycle();

    // ---------------- T1: reset during a host read ----------------
    applyStimulus(1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("t1_gnt_N", outFlags(), 32'b1000000);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t1_in_issue", outFlags(), 32'b0000011);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t1_flags_after_rst", outFlags(), 32'b0000000);
    checkOutput("t1_strobe_bus_after_rst", strobeBus(), 32'h0);
    checkOutput("t1_t_rdata_after_rst", 32'(ifc.t_rdata), 32'h0);
    checkOutput("t1_h_rdata_after_rst", 32'(ifc.h_rdata), 32'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("t1_no_h_rvalid", 32'(ifc.h_rvalid), 32'h0);
    end

    // ---------------- T5: continuous host traffic vs waiting tuner ----------------
    nextCycle();
    applyStimulus(1, 1, 8'h44, 8'hA5, 1, 1, 8'h40, 8'h3C);
    firstTGnt  = -1;
    hGntBefore = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ifc.t_gnt && (firstTGnt < 0)) firstTGnt = k;
      if (ifc.h_gnt && (firstTGnt < 0)) hGntBefore++;
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
`ifdef ARB_AGING_EN
    checkOutput("t5_first_tgnt_cycle", 32'(firstTGnt), 32'd16);
    checkOutput("t5_hgnt_before_tgnt", 32'(hGntBefore), 32'd8);
`else
    checkOutput("t5_tgnt_never", 32'(firstTGnt), 32'hFFFF_FFFF);
    checkOutput("t5_hgnt_count", 32'(hGntBefore), 32'd20);
`endif
    nextCycle(); nextCycle();

    // ---------------- T6: preload then mixed traffic ----------------
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(1, 1, addrList[i], 8'(i * 8'h11 + 8'h07), 0, 0, 8'h00, 8'h00);
      nextCycle();
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    end

    hPend = 0; hWaitRd = 0; tPend = 0; tWaitRd = 0; gntPrev = 0; prevWe = 0;
    hWe = 0; tWe = 0; hAddr = 0; hWdata = 0; tAddr = 0; tWdata = 0;
    hExp = 0; tExp = 0; prevAddr = 0; prevWdata = 0;
    numGnt = 0; numStrobe = 0; numRd = 0; hWaitCnt = 0; tWaitCnt = 0;

    for (int cyc = 0; cyc < 620; cyc++) begin
      allowNew = (cyc < 600);
      nextCycle();
      if (allowNew && !gntPrev && !hPend && !hWaitRd && ($urandom_range(0, 2) == 0)) begin
        hPend  = 1'b1;
        hWe    = 1'($urandom_range(0, 1));
        hAddr  = addrList[$urandom_range(0, 5)];
        hWdata = 8'($urandom);
      end
      if (allowNew && !gntPrev && !tPend && !tWaitRd && ($urandom_range(0, 2) == 0)) begin
        tPend  = 1'b1;
        tWe    = 1'($urandom_range(0, 1));
        tAddr  = addrList[$urandom_range(0, 5)];
        tWdata = 8'($urandom);
      end
      applyStimulus(hPend, hWe, hAddr, hWdata, tPend, tWe, tAddr, tWdata);
      @(negedge clk);

      checkOutput("t6_strobe_excl", 32'(ifc.reg_write & ifc.reg_read), 32'h0);
      if (ifc.reg_write || ifc.reg_read) numStrobe++;
      if (gntPrev) begin
        checkOutput("t6_strobe_after_gnt",
                    32'({ifc.reg_write, ifc.reg_read, ifc.reg_index,
                         (prevWe ? ifc.reg_wdata : 8'h00)}),
                    32'({prevWe, ~prevWe, prevAddr, (prevWe ? prevWdata : 8'h00)}));
      end else begin
        checkOutput("t6_no_stray_strobe", 32'({ifc.reg_write, ifc.reg_read}), 32'h0);
      end
      gntPrev = 1'b0;

      checkOutput("t6_gnt_excl", 32'(ifc.h_gnt & ifc.t_gnt), 32'h0);
      if (ifc.h_gnt) begin
        checkOutput("t6_hgnt_requested", 32'(hPend), 32'h1);
        gntPrev = 1'b1; prevWe = hWe; prevAddr = hAddr; prevWdata = hWdata;
        if (!hWe) begin
          hWaitRd = 1'b1;
          hExp    = tbMem[hAddr];
        end
        hPend = 1'b0;
        numGnt++;
      end else if (ifc.t_gnt) begin
        checkOutput("t6_tgnt_requested", 32'(tPend), 32'h1);
        gntPrev = 1'b1; prevWe = tWe; prevAddr = tAddr; prevWdata = tWdata;
        if (!tWe) begin
          tWaitRd = 1'b1;
          tExp    = tbMem[tAddr];
        end
        tPend = 1'b0;
        numGnt++;
      end

      if (ifc.h_rvalid) begin
        checkOutput("t6_h_rvalid_owner", 32'(hWaitRd), 32'h1);
        checkOutput("t6_h_rdata", 32'(ifc.h_rdata), 32'(hExp));
        hWaitRd = 1'b0;
        numRd++;
      end
      if (ifc.t_rvalid) begin
        checkOutput("t6_t_rvalid_owner", 32'(tWaitRd), 32'h1);
        checkOutput("t6_t_rdata", 32'(ifc.t_rdata), 32'(tExp));
        tWaitRd = 1'b0;
        numRd++;
      end

      hWaitCnt = (hPend || hWaitRd) ? hWaitCnt + 1 : 0;
      tWaitCnt = (tPend || tWaitRd) ? tWaitCnt + 1 : 0;
      if (hWaitCnt > 200) begin
        checkOutput("t6_h_wait_bound", 32'(hWaitCnt), 32'd200);
        hWaitCnt = 0;
      end
      if (tWaitCnt > 200) begin
        checkOutput("t6_t_wait_bound", 32'(tWaitCnt), 32'd200);
        tWaitCnt = 0;
      end
    end

    checkOutput("t6_all_served", 32'({hPend, hWaitRd, tPend, tWaitRd}), 32'h0);
    checkOutput("t6_gnt_vs_strobe", 32'(numStrobe), 32'(numGnt));
    $display("[TB] mixed traffic: %0d grants, %0d reads returned", numGnt, numRd);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
